ftrans_sched: RTL and testbench

Frame scheduler for the inter-stage twiddle-multiply stage of the FFT pipeline. It accepts completed frames from the ping-pong frame buffer, issues read addresses to that buffer, and drives the twiddle stage's address/enable inputs one sample per enabled cycle. It counts returned valid samples to detect frame completion, and it flags lost or extra samples. It sits between the frame-buffer write side and the twiddle-multiply stage.

---
 rtl/ftrans_sched.sv | 143 ++++++++++++++
 tb/tb_ftrans_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ftrans_sched.sv
// Frame scheduler for the twiddle-multiply stage. It walks one buffered frame
// through the stage and checks that every issued sample comes back.
module ftrans_sched #(
  parameter int FFT_STG      = 7,
  parameter int TOTAL_STAGE  = 11,
  parameter int MULT_OP_DLY  = 2,
  parameter int DRAIN_MARGIN = 4
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   istart,
  input  logic                   ibank,
  output logic                   ordy,
  input  logic                   istall,
  output logic [TOTAL_STAGE-1:0] ram_raddr,
  output logic                   ram_ren,
  output logic [TOTAL_STAGE-1:0] st_iaddr,
  output logic                   st_ien,
  input  logic                   st_oen,
  output logic                   obusy,
  output logic                   odone,
  output logic                   oerr
);

  localparam int DRAIN_LOAD = MULT_OP_DLY + 2 + DRAIN_MARGIN;
  localparam int TMR_W      = $clog2(DRAIN_LOAD + 1);
  localparam logic [FFT_STG:0]   FRAME_LEN = {1'b1, {FFT_STG{1'b0}}};
  localparam logic [FFT_STG-1:0] LAST_IDX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic                   bank_reg, bank_next;
  logic [FFT_STG-1:0]     icnt_reg, icnt_next;
  logic [FFT_STG:0]       rcnt_reg, rcnt_next;
  logic [TMR_W-1:0]       tmr_reg, tmr_next;
  logic                   err_reg, err_next;
  logic                   st_ien_reg;
  logic [TOTAL_STAGE-1:0] st_iaddr_reg;
  logic [TOTAL_STAGE-1:0] issue_addr;

  // Bank bit on the MSB, sample index in the low bits, zeros between.
  always_comb begin
    issue_addr                  = '0;
    issue_addr[FFT_STG-1:0]     = icnt_reg;
    issue_addr[TOTAL_STAGE-1]   = bank_reg;
  end

  always_comb begin
    state_next = state_reg;
    bank_next  = bank_reg;
    icnt_next  = icnt_reg;
    rcnt_next  = rcnt_reg;
    tmr_next   = tmr_reg;
    err_next   = err_reg;
    ordy       = 1'b0;
    obusy      = 1'b0;
    odone      = 1'b0;
    ram_ren    = 1'b0;
    ram_raddr  = '0;

    if (st_oen) begin
      if (state_reg == IDLE || state_reg == DONE)
        err_next = 1'b1;
      if (state_reg != IDLE) begin
        rcnt_next = rcnt_reg + (FFT_STG + 1)'(1);
        if (rcnt_reg >= FRAME_LEN)
          err_next = 1'b1;
      end
    end
    if (istart && state_reg != IDLE)
      err_next = 1'b1;

    case (state_reg)
      IDLE: begin
        ordy = 1'b1;
        if (istart) begin
          bank_next  = ibank;
          icnt_next  = '0;
          rcnt_next  = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        obusy     = 1'b1;
        ram_raddr = issue_addr;
        if (!istall) begin
          ram_ren   = 1'b1;
          icnt_next = icnt_reg + FFT_STG'(1);
          if (icnt_reg == LAST_IDX) begin
            state_next = DRAIN;
            tmr_next   = TMR_W'(DRAIN_LOAD);
          end
        end
      end
      DRAIN: begin
        obusy    = 1'b1;
        tmr_next = tmr_reg - TMR_W'(1);
        // A return landing this cycle still counts toward completion.
        if (rcnt_next >= FRAME_LEN) begin
          state_next = DONE;
        end else if (tmr_reg <= TMR_W'(1)) begin
          tmr_next   = '0;
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        odone      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_reg    <= IDLE;
      bank_reg     <= 1'b0;
      icnt_reg     <= '0;
      rcnt_reg     <= '0;
      tmr_reg      <= '0;
      err_reg      <= 1'b0;
      st_ien_reg   <= 1'b0;
      st_iaddr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      bank_reg   <= bank_next;
      icnt_reg   <= icnt_next;
      rcnt_reg   <= rcnt_next;
      tmr_reg    <= tmr_next;
      err_reg    <= err_next;
      st_ien_reg <= ram_ren;
      if (ram_ren)
        st_iaddr_reg <= TOTAL_STAGE'(issue_addr[FFT_STG-1:0]);
    end
  end

  assign st_ien   = st_ien_reg;
  assign st_iaddr = st_iaddr_reg;
  assign oerr     = err_reg;

endmodule

// File: tb/tb_ftrans_sched.sv
// Directed-plus-random bench for ftrans_sched: a delay-line model of the
// twiddle stage returns samples, and frame-level expectations come from timing rules.
module tb_ftrans_sched;
  localparam int FFT_STG      = 3;
  localparam int TOTAL_STAGE  = 11;
  localparam int MULT_OP_DLY  = 2;
  localparam int DRAIN_MARGIN = 4;
  localparam int N            = 1 << FFT_STG;
  localparam int DRAIN_LOAD   = MULT_OP_DLY + 2 + DRAIN_MARGIN;

  logic clk = 1'b0;
  logic rst_n;
  logic istart, ibank, istall, st_oen;
  logic ordy, ram_ren, st_ien, obusy, odone, oerr;
  logic [TOTAL_STAGE-1:0] ram_raddr, st_iaddr;

  ftrans_sched #(
    .FFT_STG(FFT_STG), .TOTAL_STAGE(TOTAL_STAGE),
    .MULT_OP_DLY(MULT_OP_DLY), .DRAIN_MARGIN(DRAIN_MARGIN)
  ) dut (
    .iclk(clk), .irst_n(rst_n), .istart(istart), .ibank(ibank), .ordy(ordy),
    .istall(istall), .ram_raddr(ram_raddr), .ram_ren(ram_ren),
    .st_iaddr(st_iaddr), .st_ien(st_ien), .st_oen(st_oen),
    .obusy(obusy), .odone(odone), .oerr(oerr)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ret_idx = 0;
  int   drop_idx = -1;
  int   done_at = 0;
  logic exp_err = 1'b0;
  logic drv_start = 1'b0, drv_bank = 1'b0, drv_stall = 1'b0, drv_oen_force = 1'b0;
  logic pipe [0:MULT_OP_DLY];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i <= MULT_OP_DLY; i++) pipe[i] = 1'b0;
  endtask

  // One clock: drive inputs at negedge, sample #1 later, advance stage model.
  task automatic tick();
    @(negedge clk);
    istart = drv_start;
    ibank  = drv_bank;
    istall = drv_stall;
    st_oen = (pipe[MULT_OP_DLY] && (ret_idx != drop_idx)) || drv_oen_force;
    if (pipe[MULT_OP_DLY]) ret_idx++;
    #1;
    for (int i = MULT_OP_DLY; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = st_ien;
    cyc++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    drv_start = 1'b0; drv_stall = 1'b0; drv_oen_force = 1'b0;
    clear_pipe();
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one frame starting with istart in the current cycle (DUT must be idle).
  task automatic run_frame(input logic bank, input int stall_pct, input int st_after,
                           input int st_len, input int drop, input int poke);
    int   issued, nstall, exp_done, fix_left, c_last;
    logic stall, exp_ren, prev_ren;
    logic [TOTAL_STAGE-1:0] exp_addr;
    issued = 0; nstall = 0; exp_done = 1000; fix_left = st_len; prev_ren = 1'b0; c_last = 0;
    ret_idx = 0; drop_idx = drop;
    drv_start = 1'b1; drv_bank = bank; drv_stall = 1'b0;
    tick();
    chk("start_ordy", ordy, 1);
    chk("start_obusy", obusy, 0);
    drv_start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      stall = 1'b0;
      if (issued < N) begin
        if (issued == st_after + 1 && fix_left > 0) begin
          stall = 1'b1;
          fix_left--;
        end else if ($urandom_range(99, 0) < stall_pct) begin
          stall = 1'b1;
        end
      end
      drv_stall = stall;
      drv_start = (c == poke);
      drv_bank  = 1'($urandom_range(1, 0));
      tick();
      exp_ren = (issued < N) && !stall;
      chk("ram_ren", ram_ren, exp_ren);
      chk("st_ien", st_ien, prev_ren);
      if (issued > 0) chk("st_iaddr", st_iaddr, issued - 1);
      if (exp_ren) begin
        exp_addr = '0;
        exp_addr[TOTAL_STAGE-1] = bank;
        exp_addr[FFT_STG-1:0]   = issued[FFT_STG-1:0];
        chk("ram_raddr", ram_raddr, exp_addr);
        issued++;
        if (issued == N)
          exp_done = (drop >= 0) ? c + 1 + DRAIN_LOAD : N + MULT_OP_DLY + 3 + nstall;
      end else if (issued < N) begin
        nstall++;
      end
      if (odone === 1'b1) done_at = cyc;
      if (drop >= 0 && c == exp_done) exp_err = 1'b1;
      chk("odone", odone, (c == exp_done));
      chk("obusy", obusy, (c < exp_done));
      chk("ordy_busy", ordy, 0);
      chk("oerr", oerr, exp_err);
      if (c == poke) exp_err = 1'b1;
      prev_ren = exp_ren;
      c_last = c;
      if (c == exp_done) break;
    end
    drv_start = 1'b0; drv_stall = 1'b0;
    chk("frame_done_cycle", c_last, exp_done);
    $display("[TB] frame bank=%0d stall_pct=%0d drop=%0d poke=%0d stalls=%0d done_off=%0d oerr=%0d",
             bank, stall_pct, drop, poke, nstall, c_last, oerr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int d1;
    rst_n = 1'b0; istart = 1'b0; ibank = 1'b0; istall = 1'b0; st_oen = 1'b0;
    clear_pipe();
    reset_dut();

    // Reset state
    tick();
    chk("rst_ordy", ordy, 1);
    chk("rst_ram_ren", ram_ren, 0);
    chk("rst_ram_raddr", ram_raddr, 0);
    chk("rst_st_ien", st_ien, 0);
    chk("rst_st_iaddr", st_iaddr, 0);
    chk("rst_obusy", obusy, 0);
    chk("rst_odone", odone, 0);
    chk("rst_oerr", oerr, 0);

    // Plain frame on bank 1, then a back-to-back frame on bank 0
    run_frame(1'b1, 0, -1, 0, -1, -1);
    d1 = done_at;
    run_frame(1'b0, 0, -1, 0, -1, -1);
    chk("b2b_odone_gap", done_at - d1, N + MULT_OP_DLY + 4);

    // Three stall cycles right after index 2
    run_frame(1'b1, 0, 2, 3, -1, -1);

    // Random banks and random back-pressure
    for (int f = 0; f < 4; f++)
      run_frame(1'($urandom_range(1, 0)), 30, -1, 0, -1, -1);

    // istart during ISSUE is ignored but flags an error
    run_frame(1'b0, 0, -1, 0, -1, 4);

    // Reset asserted mid-frame while icnt=4
    drv_start = 1'b1; drv_bank = 1'b1;
    tick();
    drv_start = 1'b0;
    repeat (4) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    chk("midrst_ram_ren", ram_ren, 0);
    chk("midrst_ram_raddr", ram_raddr, 0);
    chk("midrst_st_ien", st_ien, 0);
    chk("midrst_st_iaddr", st_iaddr, 0);
    chk("midrst_obusy", obusy, 0);
    chk("midrst_ordy", ordy, 1);
    chk("midrst_oerr", oerr, 0);
    clear_pipe();
    repeat (2) begin
      tick();
      chk("midrst_odone", odone, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_pipe();
    run_frame(1'b1, 0, -1, 0, -1, -1);

    // st_oen while idle
    drv_oen_force = 1'b1;
    tick();
    chk("idle_oen_ordy", ordy, 1);
    chk("idle_oen_oerr_before", oerr, 0);
    drv_oen_force = 1'b0;
    tick();
    chk("idle_oen_oerr_after", oerr, 1);

    // Lost sample: drain timer expiry
    reset_dut();
    run_frame(1'b1, 0, -1, 0, 5, -1);
    tick();
    chk("drop_back_idle_ordy", ordy, 1);
    chk("drop_back_idle_obusy", obusy, 0);
    chk("drop_back_idle_odone", odone, 0);
    chk("drop_oerr_sticky", oerr, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
